dmem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares port A of the data memory between core 0 and core 1 of the multicore processor.
- Each core presents one load/store at a time and is stalled until the arbiter returns a one-cycle completion pulse.
- The block registers the winning request, drives the memory for exactly one cycle, and captures the read data.
- It then routes the captured data back to the owning core.

---
 rtl/dmem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing data-memory port A between two cores.
// Each access runs IDLE -> ISSUE (memory driven) -> RESP (completion pulse).
module dmem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit FIRST_PRI = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              C0_Req,
    input  logic              C0_Write,
    input  logic [DATA_W-1:0] C0_Address,
    input  logic [DATA_W-1:0] C0_WriteData,
    output logic              C0_Stall,
    output logic              C0_Valid,
    output logic [DATA_W-1:0] C0_ReadData,
    input  logic              C1_Req,
    input  logic              C1_Write,
    input  logic [DATA_W-1:0] C1_Address,
    input  logic [DATA_W-1:0] C1_WriteData,
    output logic              C1_Stall,
    output logic              C1_Valid,
    output logic [DATA_W-1:0] C1_ReadData,
    output logic [DATA_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Mem_MemWrite,
    output logic              Mem_MemRead,
    input  logic [DATA_W-1:0] Mem_ReadData,
    output logic              Busy,
    output logic [1:0]        Dbg_State
);

    // Handshake: a core holds Req (and its address/data) stable until it sees
    // its Valid pulse; the core advances on the rising edge that ends Valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] c0_rdata_q, c0_rdata_d;
    logic [DATA_W-1:0] c1_rdata_q, c1_rdata_d;
    logic              grant;

    // Core 1 wins when alone, or on a tie when core 0 was granted last.
    assign grant = C1_Req & (~C0_Req | ~last_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        c0_rdata_d = c0_rdata_q;
        c1_rdata_d = c1_rdata_q;
        case (state_q)
            IDLE: begin
                if (C0_Req || C1_Req) begin
                    owner_d = grant;
                    write_d = grant ? C1_Write     : C0_Write;
                    addr_d  = grant ? C1_Address   : C0_Address;
                    wdata_d = grant ? C1_WriteData : C0_WriteData;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!write_q) begin
                    if (owner_q) c1_rdata_d = Mem_ReadData;
                    else         c0_rdata_d = Mem_ReadData;
                end
                state_d = RESP;
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= ~FIRST_PRI;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            c0_rdata_q <= '0;
            c1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c0_rdata_q <= c0_rdata_d;
            c1_rdata_q <= c1_rdata_d;
        end
    end

    // Address/data registers only change on a grant, so they hold outside ISSUE.
    assign Mem_Address   = addr_q;
    assign Mem_WriteData = wdata_q;
    assign Mem_MemWrite  = (state_q == ISSUE) &  write_q;
    assign Mem_MemRead   = (state_q == ISSUE) & ~write_q;

    assign C0_Valid    = (state_q == RESP) & ~owner_q;
    assign C1_Valid    = (state_q == RESP) &  owner_q;
    assign C0_Stall    = C0_Req & ~C0_Valid;
    assign C1_Stall    = C1_Req & ~C1_Valid;
    assign C0_ReadData = c0_rdata_q;
    assign C1_ReadData = c1_rdata_q;
    assign Busy        = (state_q != IDLE);
    assign Dbg_State   = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a cycle table for contention after
// reset, then hand sequences for store/load, Req drop and async reset.
module tb_dmem_port_arbiter;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;
    localparam logic [31:0] A5 = 32'hA5A50001;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        C0_Req, C0_Write, C1_Req, C1_Write;
    logic [31:0] C0_Address, C0_WriteData, C1_Address, C1_WriteData;
    logic        C0_Stall, C0_Valid, C1_Stall, C1_Valid;
    logic [31:0] C0_ReadData, C1_ReadData;
    logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
    logic        Mem_MemWrite, Mem_MemRead, Busy;
    logic [1:0]  Dbg_State;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    dmem_port_arbiter #(.DATA_W(32), .FIRST_PRI(1'b0)) dut (
        .Clk(Clk), .Reset(Reset),
        .C0_Req(C0_Req), .C0_Write(C0_Write), .C0_Address(C0_Address),
        .C0_WriteData(C0_WriteData), .C0_Stall(C0_Stall), .C0_Valid(C0_Valid),
        .C0_ReadData(C0_ReadData),
        .C1_Req(C1_Req), .C1_Write(C1_Write), .C1_Address(C1_Address),
        .C1_WriteData(C1_WriteData), .C1_Stall(C1_Stall), .C1_Valid(C1_Valid),
        .C1_ReadData(C1_ReadData),
        .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
        .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
        .Mem_ReadData(Mem_ReadData), .Busy(Busy), .Dbg_State(Dbg_State)
    );

    // Memory model: unwritten words fall back to fixed preload contents.
    logic [31:0]  mem [256];
    logic [255:0] mem_vld = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h10:  return DB;
            32'h20:  return CF;
            32'h30:  return A5;
            default: return 32'h0;
        endcase
    endfunction

    assign Mem_ReadData = mem_vld[Mem_Address[9:2]] ? mem[Mem_Address[9:2]]
                                                    : init_word(Mem_Address);

    always @(negedge Clk) begin
        if (Mem_MemWrite) begin
            mem[Mem_Address[9:2]]     <= Mem_WriteData;
            mem_vld[Mem_Address[9:2]] <= 1'b1;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input logic [1:0] exp);
        total++;
        if (Dbg_State !== exp) begin
            bad++;
            $display("FAIL %s: state got %0d want %0d", name, Dbg_State, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_c0(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        C0_Req = req; C0_Write = wr; C0_Address = a; C0_WriteData = d;
    endtask

    task automatic drive_c1(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        C1_Req = req; C1_Write = wr; C1_Address = a; C1_WriteData = d;
    endtask

    typedef struct {
        logic        req0, req1;
        logic [1:0]  st;
        logic        v0, v1, s0, s1, rd;
        logic [31:0] addr, rd0, rd1;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic r1, input logic [1:0] st,
                                input logic v0, input logic v1, input logic s0,
                                input logic s1, input logic rd, input logic [31:0] a,
                                input logic [31:0] d0, input logic [31:0] d1);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.st = st; v.v0 = v0; v.v1 = v1;
        v.s0 = s0; v.s1 = s1; v.rd = rd; v.addr = a; v.rd0 = d0; v.rd1 = d1;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   mw;
        int   n;

        // Both cores load continuously from reset: grants 0,1,0,1 then idle.
        //              r0    r1    st    v0    v1    s0    s1    rd    addr    rd0    rd1
        tbl[0]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 32'h0);
        tbl[1]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0, 32'h0);
        tbl[2]  = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, DB,    32'h0);
        tbl[3]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, DB,    32'h0);
        tbl[4]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, DB,    32'h0);
        tbl[5]  = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, DB,    CF);
        tbl[6]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, DB,    CF);
        tbl[7]  = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, DB,    CF);
        tbl[8]  = mk(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, DB,    CF);
        tbl[9]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, DB,    CF);
        tbl[10] = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, DB,    CF);
        tbl[11] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, DB,    CF);
        tbl[12] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, DB,    CF);
        tbl[13] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, DB,    CF);

        Reset = 1'b1;
        drive_c0(1'b0, 1'b0, 32'h0, 32'h0);
        drive_c1(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk_st("reset state", 2'd0);
        chk1("reset busy", Busy, 1'b0);
        chk1("reset memwrite", Mem_MemWrite, 1'b0);
        chk1("reset memread", Mem_MemRead, 1'b0);
        chkw("reset mem_address", Mem_Address, 32'h0);
        chkw("reset mem_wdata", Mem_WriteData, 32'h0);
        chkw("reset c0_rdata", C0_ReadData, 32'h0);
        chkw("reset c1_rdata", C1_ReadData, 32'h0);
        @(posedge Clk);
        next_cycle();
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive_c0(tbl[i].req0, 1'b0, 32'h10, 32'h0);
            drive_c1(tbl[i].req1, 1'b0, 32'h20, 32'h0);
            @(negedge Clk);
            chk_st($sformatf("row%0d state", i), tbl[i].st);
            chk1($sformatf("row%0d busy", i), Busy, tbl[i].st != 2'd0);
            chk1($sformatf("row%0d c0_valid", i), C0_Valid, tbl[i].v0);
            chk1($sformatf("row%0d c1_valid", i), C1_Valid, tbl[i].v1);
            chk1($sformatf("row%0d c0_stall", i), C0_Stall, tbl[i].s0);
            chk1($sformatf("row%0d c1_stall", i), C1_Stall, tbl[i].s1);
            chk1($sformatf("row%0d memread", i), Mem_MemRead, tbl[i].rd);
            chk1($sformatf("row%0d memwrite", i), Mem_MemWrite, 1'b0);
            chkw($sformatf("row%0d mem_address", i), Mem_Address, tbl[i].addr);
            chkw($sformatf("row%0d c0_rdata", i), C0_ReadData, tbl[i].rd0);
            chkw($sformatf("row%0d c1_rdata", i), C1_ReadData, tbl[i].rd1);
            next_cycle();
        end

        // Core 1 store to 0x40 followed by a load of the same word.
        mw = 0;
        drive_c1(1'b1, 1'b1, 32'h40, 32'h12345678);
        @(negedge Clk);
        chk_st("st idle", 2'd0);
        mw += int'(Mem_MemWrite);
        next_cycle();
        @(negedge Clk);
        chk1("st memwrite", Mem_MemWrite, 1'b1);
        chk1("st memread", Mem_MemRead, 1'b0);
        chkw("st mem_address", Mem_Address, 32'h40);
        chkw("st mem_wdata", Mem_WriteData, 32'h12345678);
        chkw("st c1_rdata issue", C1_ReadData, CF);
        mw += int'(Mem_MemWrite);
        next_cycle();
        @(negedge Clk);
        chk1("st c1_valid", C1_Valid, 1'b1);
        chk1("st c1_stall", C1_Stall, 1'b0);
        chkw("st c1_rdata resp", C1_ReadData, CF);
        mw += int'(Mem_MemWrite);
        next_cycle();
        drive_c1(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge Clk);
        chk_st("ld idle", 2'd0);
        mw += int'(Mem_MemWrite);
        next_cycle();
        @(negedge Clk);
        chk1("ld memread", Mem_MemRead, 1'b1);
        mw += int'(Mem_MemWrite);
        next_cycle();
        @(negedge Clk);
        chk1("ld c1_valid", C1_Valid, 1'b1);
        chkw("ld c1_rdata", C1_ReadData, 32'h12345678);
        mw += int'(Mem_MemWrite);
        chkw("store write pulses", 32'(mw), 32'd1);
        next_cycle();
        drive_c1(1'b0, 1'b0, 32'h0, 32'h0);

        // Core 0 drops Req during ISSUE: access completes once, no reissue.
        drive_c0(1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge Clk);
        chk_st("drop idle", 2'd0);
        next_cycle();
        drive_c0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge Clk);
        chk1("drop memread", Mem_MemRead, 1'b1);
        chkw("drop mem_address", Mem_Address, 32'h30);
        chk1("drop c0_stall", C0_Stall, 1'b0);
        next_cycle();
        @(negedge Clk);
        chk1("drop c0_valid", C0_Valid, 1'b1);
        chkw("drop c0_rdata", C0_ReadData, A5);
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            @(negedge Clk);
            chk1($sformatf("drop no reissue busy %0d", j), Busy, 1'b0);
            chk1($sformatf("drop no reissue memread %0d", j), Mem_MemRead, 1'b0);
        end

        // Asynchronous reset in the middle of a core 1 store.
        next_cycle();
        drive_c1(1'b1, 1'b1, 32'h90, 32'h77);
        @(negedge Clk);
        chk_st("rst idle", 2'd0);
        next_cycle();
        @(negedge Clk);
        chk1("rst pre memwrite", Mem_MemWrite, 1'b1);
        chk1("rst pre busy", Busy, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk1("rst memwrite", Mem_MemWrite, 1'b0);
        chk1("rst memread", Mem_MemRead, 1'b0);
        chk1("rst busy", Busy, 1'b0);
        chk1("rst c1_valid", C1_Valid, 1'b0);
        chk_st("rst state", 2'd0);
        chkw("rst c0_rdata", C0_ReadData, 32'h0);
        chkw("rst c1_rdata", C1_ReadData, 32'h0);
        drive_c1(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        Reset = 1'b0;
        drive_c0(1'b1, 1'b0, 32'h10, 32'h0);
        drive_c1(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge Clk);
        chk_st("post rst idle", 2'd0);
        next_cycle();
        @(negedge Clk);
        chkw("post rst first grant addr", Mem_Address, 32'h10);
        chk1("post rst memread", Mem_MemRead, 1'b1);
        next_cycle();
        @(negedge Clk);
        chk1("post rst c0_valid", C0_Valid, 1'b1);
        chk1("post rst c1_valid", C1_Valid, 1'b0);
        chk1("post rst c1_stall", C1_Stall, 1'b1);
        chkw("post rst c0_rdata", C0_ReadData, DB);
        next_cycle();
        drive_c0(1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (n < 8) begin
            @(negedge Clk);
            if (C1_Valid === 1'b1) break;
            @(posedge Clk);
            n++;
        end
        chkw("post rst c1 wait cycles", 32'(n), 32'd2);
        chkw("post rst c1_rdata", C1_ReadData, CF);
        next_cycle();
        drive_c1(1'b0, 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
